ccr_shadow_stack: RTL
=====================

Name: ccr_shadow_stack

Overview:
Saves and restores the 4-bit condition code register (Z,N,C,V) across interrupts and calls. On a save request it reads the live CCR value and pushes it onto a small LIFO. On a restore request (RTI/RET) it pops the newest entry and drives it, with a one-cycle load strobe, back into the CCR's write port. It sits between the control unit and the CCR as the read-side and restore path of the flag interface.

Parameters:
DEPTH, 4, number of saved CCR entries (nesting depth); power of 2, minimum 2
FLAG_W, 4, flag vector width; bit 0 Z, bit 1 N, bit 2 C, bit 3 V

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
ccr_in  input  FLAG_W  live CCR value, sampled on save
save  input  1  push request (interrupt entry / CALL), single-cycle pulse
restore  input  1  pop request (RTI / RET), single-cycle pulse
ccr_out  output  FLAG_W  restored flag vector, registered
ccr_load  output  1  one-cycle strobe; CCR loads ccr_out when high
level  output  $clog2(DEPTH)+1  current number of stored entries
full  output  1  level == DEPTH
empty  output  1  level == 0
overflow_err  output  1  sticky; set by a dropped save
underflow_err  output  1  sticky; set by a restore while empty

Behaviour:
- Reset (async): level=0, ccr_out=0, ccr_load=0, overflow_err=0, underflow_err=0, empty=1, full=0. Stack contents are don't-care and are not cleared.
- full and empty are combinational from level. All other outputs are registered.
- Save only, not full: mem[level] <= ccr_in; level+1. ccr_load stays 0.
- Save only, full: entry dropped; level unchanged; overflow_err <= 1.
- Restore only, not empty: at the next edge, ccr_out <= mem[level-1], ccr_load <= 1 for exactly one cycle, level-1. Latency is 1 clock from the restore sample to the ccr_load/ccr_out valid edge.
- Restore only, empty: ccr_out unchanged; ccr_load stays 0; underflow_err <= 1.
- Save and restore in the same cycle, not empty: swap.
  - ccr_out <= mem[level-1]; ccr_load <= 1.
  - mem[level-1] <= ccr_in.
  - level unchanged.
  - The read uses the pre-write value.
- Save and restore in the same cycle, empty: pass-through.
  - ccr_out <= ccr_in; ccr_load <= 1.
  - level stays 0; no error flag set.
- ccr_load is 0 in every cycle without a successful restore. Back-to-back restores produce back-to-back strobes.
- Error flags are cleared only by rst.
- rst asserted mid-operation: a pending ccr_load is killed immediately (async) and all saved context is lost.
- Pointer arithmetic is unsigned, width $clog2(DEPTH)+1. It never wraps because full and empty are guarded.

Optional Feature:
CCR_SHADOW_PARITY_EN
- Defined:
  - Each entry stores an extra even-parity bit computed from ccr_in at save.
  - On every successful restore the stored parity is checked. A mismatch sets a sticky output parity_err (1 bit, reset 0) in the same cycle as ccr_load. ccr_out is still delivered.
  - The swap and pass-through cases check the popped entry only; pass-through is never an error.
- Undefined: no parity storage, no parity_err port.

Decomposition:
- Package ccr_pkg:
  - FLAG_W, plus flag index constants FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
  - typedef flags_t (logic [FLAG_W-1:0]).
  - Shared with the CCR and the ALU.
- Sub-module ccr_stack_mem: a DEPTH x (FLAG_W[+1]) register file with one synchronous write port and one combinational read port addressed by level-1.
- Pointer, error and strobe logic stay in the top module.

Test Plan:
- Reset, then restore → ccr_load stays 0, underflow_err=1, ccr_out=0, level=0.
- Save 4'b0001, save 4'b1010, then restore, restore → ccr_out=4'b1010 then 4'b0001 on consecutive cycles, ccr_load high both cycles, empty=1 at the end.
- Fill 4 saves, then a 5th save of 4'b1111 → full=1, overflow_err=1, level=4. Four restores return the original four values in LIFO order; the 5th value never appears.
- level=2 with top=4'b0100; save and restore together with ccr_in=4'b1000 → ccr_out=4'b0100, ccr_load=1, level=2. A following restore returns 4'b1000.
- Empty; save and restore together with ccr_in=4'b0110 → ccr_out=4'b0110, ccr_load=1, no error flags.
- Assert rst in the cycle after a restore request → ccr_load drops immediately, level=0. With CCR_SHADOW_PARITY_EN, force a stored-bit flip, then restore → parity_err=1.

Source files
------------

// File: rtl/ccr_pkg.sv
// Condition code register types shared by the CCR, the ALU and the shadow stack.
// Flag order in a flags_t vector: bit 0 Z, bit 1 N, bit 2 C, bit 3 V.
package ccr_pkg;

    localparam int FLAG_W = 4;
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef logic [FLAG_W-1:0] flags_t;

    function automatic logic even_par(input flags_t f);
        return ^f;
    endfunction

endpackage

// File: rtl/ccr_stack_mem.sv
// Register file backing the CCR shadow stack.
// One synchronous write port and one combinational read port.
module ccr_stack_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ccr_shadow_stack.sv
// LIFO save/restore of the CCR across interrupts and calls.
// Define CCR_SHADOW_PARITY_EN to store and check an even-parity bit per entry.
module ccr_shadow_stack
    import ccr_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int FLAG_W = ccr_pkg::FLAG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLAG_W-1:0]          ccr_in,
    input  logic                       save,
    input  logic                       restore,
    output logic [FLAG_W-1:0]          ccr_out,
    output logic                       ccr_load,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow_err,
    output logic                       underflow_err
`ifdef CCR_SHADOW_PARITY_EN
    ,
    output logic                       parity_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef CCR_SHADOW_PARITY_EN
    localparam int EW = FLAG_W + 1;
`else
    localparam int EW = FLAG_W;
`endif

    logic          we;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [EW-1:0] wdata;
    logic [EW-1:0] rdata;
    logic          pop;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign pop   = restore && !empty;
    assign raddr = AW'(level - LW'(1));

`ifdef CCR_SHADOW_PARITY_EN
    assign wdata = {even_par(ccr_in), ccr_in};
`else
    assign wdata = ccr_in;
`endif

    // A swap overwrites the top entry; a plain push writes one above it.
    always_comb begin
        we    = 1'b0;
        waddr = AW'(level);
        if (save && restore && !empty) begin
            we    = 1'b1;
            waddr = raddr;
        end else if (save && !restore && !full) begin
            we = 1'b1;
        end
    end

    ccr_stack_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level         <= '0;
            ccr_out       <= '0;
            ccr_load      <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            ccr_load <= 1'b0;
            case ({save, restore})
                2'b11: begin
                    ccr_load <= 1'b1;
                    ccr_out  <= empty ? ccr_in : rdata[FLAG_W-1:0];
                end
                2'b10: begin
                    if (full) overflow_err <= 1'b1;
                    else      level        <= level + LW'(1);
                end
                2'b01: begin
                    if (empty) begin
                        underflow_err <= 1'b1;
                    end else begin
                        ccr_load <= 1'b1;
                        ccr_out  <= rdata[FLAG_W-1:0];
                        level    <= level - LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CCR_SHADOW_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (pop && (^rdata)) begin
            parity_err <= 1'b1;
        end
    end
`endif

endmodule
